// File: rtl/avg_threshold_monitor.sv
// Alarm monitor for an averaged sample stream.
// The alarm rises after DEBOUNCE consecutive valid samples above thr_high.
// It falls after DEBOUNCE consecutive valid samples below thr_low.
// It reports the peak of each finished alarm episode and counts alarm rises.
//
// state     | meaning
// ----------+------------------------------------------------------------
// BELOW     | alarm low, no debounce in progress
// RISE_PEND | alarm low, counting consecutive samples above thr_high
// ABOVE     | alarm high, tracking the episode peak
// FALL_PEND | alarm high, counting consecutive samples below thr_low
module avg_threshold_monitor #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] avg_in,
    input  logic             avg_valid,
    input  logic [WIDTH-1:0] thr_high,
    input  logic [WIDTH-1:0] thr_low,
    input  logic             clear,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             alarm_fall,
    output logic [WIDTH-1:0] peak_out,
    output logic             peak_valid,
    output logic [CNT_W-1:0] event_count,
    output logic             cfg_err
);

    typedef enum logic [1:0] {BELOW, RISE_PEND, ABOVE, FALL_PEND} state_t;

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE);

    state_t           state_q, state_d;
    logic [3:0]       deb_cnt_q, deb_cnt_d;
    logic [WIDTH-1:0] trk_q, trk_d;
    logic [WIDTH-1:0] peak_q, peak_d;
    logic             pv_q, pv_d;
    logic             rise_q, fall_q, cfg_err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             rise_qual, fall_qual;
    logic             alarm_now, alarm_next, rise_d, fall_d;
    logic [WIDTH-1:0] trk_max;
    logic [3:0]       deb_inc;

    assign rise_qual  = (avg_in > thr_high);
    assign fall_qual  = (avg_in < thr_low);
    assign trk_max    = (avg_in > trk_q) ? avg_in : trk_q;
    assign deb_inc    = deb_cnt_q + 4'd1;
    assign alarm_now  = (state_q == ABOVE) || (state_q == FALL_PEND);
    assign alarm_next = (state_d == ABOVE) || (state_d == FALL_PEND);
    assign rise_d     = !alarm_now && alarm_next;
    assign fall_d     = alarm_now && !alarm_next;

    // Next state, debounce count, peak tracking and peak capture.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        trk_d     = trk_q;
        peak_d    = peak_q;
        pv_d      = 1'b0;
        if (cfg_err_q) begin
            // Inconsistent thresholds: drop the alarm without reporting a peak.
            state_d   = BELOW;
            deb_cnt_d = 4'd0;
            trk_d     = '0;
        end else if (avg_valid) begin
            unique case (state_q)
                BELOW: begin
                    if (rise_qual) begin
                        trk_d = avg_in;
                        if (DEB_LAST == 4'd1) begin
                            state_d   = ABOVE;
                            deb_cnt_d = 4'd0;
                        end else begin
                            state_d   = RISE_PEND;
                            deb_cnt_d = 4'd1;
                        end
                    end
                end
                RISE_PEND: begin
                    if (rise_qual) begin
                        trk_d = trk_max;
                        if (deb_inc == DEB_LAST) begin
                            state_d   = ABOVE;
                            deb_cnt_d = 4'd0;
                        end else begin
                            deb_cnt_d = deb_inc;
                        end
                    end else begin
                        state_d   = BELOW;
                        deb_cnt_d = 4'd0;
                        trk_d     = '0;
                    end
                end
                ABOVE: begin
                    trk_d = trk_max;
                    if (fall_qual) begin
                        if (DEB_LAST == 4'd1) begin
                            state_d   = BELOW;
                            deb_cnt_d = 4'd0;
                            peak_d    = trk_max;
                            pv_d      = 1'b1;
                            trk_d     = '0;
                        end else begin
                            state_d   = FALL_PEND;
                            deb_cnt_d = 4'd1;
                        end
                    end
                end
                FALL_PEND: begin
                    trk_d = trk_max;
                    if (fall_qual) begin
                        if (deb_inc == DEB_LAST) begin
                            state_d   = BELOW;
                            deb_cnt_d = 4'd0;
                            peak_d    = trk_max;
                            pv_d      = 1'b1;
                            trk_d     = '0;
                        end else begin
                            deb_cnt_d = deb_inc;
                        end
                    end else begin
                        state_d   = ABOVE;
                        deb_cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d   = BELOW;
                    deb_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // State, pulses, peak and config-error registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= BELOW;
            deb_cnt_q <= 4'd0;
            trk_q     <= '0;
            peak_q    <= '0;
            pv_q      <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            trk_q     <= trk_d;
            peak_q    <= peak_d;
            pv_q      <= pv_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            cfg_err_q <= (thr_low > thr_high);
        end
    end

    // Saturating rise counter; clear wins over a coincident rise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (rise_d && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign alarm       = alarm_now;
    assign alarm_rise  = rise_q;
    assign alarm_fall  = fall_q;
    assign peak_out    = peak_q;
    assign peak_valid  = pv_q;
    assign event_count = cnt_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_avg_threshold_monitor.sv
// Scoreboard bench for avg_threshold_monitor (DEBOUNCE=3, 8-bit samples).
// A second instance with a 2-bit counter exercises counter saturation.
module tb_avg_threshold_monitor;

    localparam int DEB = 3;

    logic        clk, rst, avg_valid, clear;
    logic [7:0]  avg_in, thr_high, thr_low;
    logic        alarm, alarm_rise, alarm_fall, peak_valid, cfg_err;
    logic [7:0]  peak_out;
    logic [15:0] event_count;
    logic        s_alarm, s_rise, s_fall, s_pv, s_cfg;
    logic [7:0]  s_peak;
    logic [1:0]  s_cnt;

    avg_threshold_monitor #(.WIDTH(8), .DEBOUNCE(DEB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .avg_in(avg_in), .avg_valid(avg_valid),
        .thr_high(thr_high), .thr_low(thr_low), .clear(clear),
        .alarm(alarm), .alarm_rise(alarm_rise), .alarm_fall(alarm_fall),
        .peak_out(peak_out), .peak_valid(peak_valid),
        .event_count(event_count), .cfg_err(cfg_err)
    );

    avg_threshold_monitor #(.WIDTH(8), .DEBOUNCE(DEB), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .avg_in(avg_in), .avg_valid(avg_valid),
        .thr_high(thr_high), .thr_low(thr_low), .clear(clear),
        .alarm(s_alarm), .alarm_rise(s_rise), .alarm_fall(s_fall),
        .peak_out(s_peak), .peak_valid(s_pv),
        .event_count(s_cnt), .cfg_err(s_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        alarm, rise, fall, pv, cfg;
        logic [7:0]  peak;
        logic [15:0] cnt;
        logic [1:0]  cnt_s;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;
    int pv_seen = 0;
    int rise_seen = 0;
    int fall_seen = 0;

    // reference model state
    logic        m_alarm = 0, m_cfg = 0;
    int          m_run = 0;
    logic [7:0]  m_trk = 0, m_peak = 0;
    logic [15:0] m_cnt = 0;
    logic [1:0]  m_cnts = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge(output exp_t e);
        logic prev;
        logic pv;
        prev = m_alarm;
        pv   = 1'b0;
        if (!rst) begin
            m_alarm = 0; m_cfg = 0; m_run = 0; m_trk = 0; m_peak = 0;
            m_cnt = 0; m_cnts = 0;
            e = '{alarm: 0, rise: 0, fall: 0, pv: 0, cfg: 0, peak: 0, cnt: 0, cnt_s: 0};
            return;
        end
        if (m_cfg) begin
            m_alarm = 0; m_run = 0; m_trk = 0;
        end else if (avg_valid) begin
            if (!m_alarm) begin
                if (avg_in > thr_high) begin
                    m_trk = (m_run == 0 || avg_in > m_trk) ? avg_in : m_trk;
                    m_run++;
                    if (m_run == DEB) begin m_alarm = 1; m_run = 0; end
                end else begin
                    m_run = 0; m_trk = 0;
                end
            end else begin
                if (avg_in > m_trk) m_trk = avg_in;
                if (avg_in < thr_low) begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_alarm = 0; m_run = 0; m_peak = m_trk; m_trk = 0; pv = 1;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
        if (clear) begin
            m_cnt = 0; m_cnts = 0;
        end else if (!prev && m_alarm) begin
            if (m_cnt != 16'hFFFF) m_cnt++;
            if (m_cnts != 2'b11) m_cnts++;
        end
        m_cfg = (thr_low > thr_high);
        e.alarm = m_alarm;
        e.rise  = !prev && m_alarm;
        e.fall  = prev && !m_alarm;
        e.pv    = pv;
        e.cfg   = m_cfg;
        e.peak  = m_peak;
        e.cnt   = m_cnt;
        e.cnt_s = m_cnts;
    endtask

    task automatic step(input logic v, input logic [7:0] a, input logic clr);
        exp_t e;
        exp_t got;
        avg_valid = v;
        avg_in    = a;
        clear     = clr;
        @(posedge clk);
        model_edge(e);
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        chk("alarm", 32'(alarm), 32'(got.alarm));
        chk("alarm_rise", 32'(alarm_rise), 32'(got.rise));
        chk("alarm_fall", 32'(alarm_fall), 32'(got.fall));
        chk("peak_valid", 32'(peak_valid), 32'(got.pv));
        chk("peak_out", 32'(peak_out), 32'(got.peak));
        chk("event_count", 32'(event_count), 32'(got.cnt));
        chk("cfg_err", 32'(cfg_err), 32'(got.cfg));
        chk("sat_alarm", 32'(s_alarm), 32'(got.alarm));
        chk("sat_pulses", {29'd0, s_rise, s_fall, s_pv}, {29'd0, got.rise, got.fall, got.pv});
        chk("sat_peak", 32'(s_peak), 32'(got.peak));
        chk("sat_cfg", 32'(s_cfg), 32'(got.cfg));
        chk("sat_count", 32'(s_cnt), 32'(got.cnt_s));
        pv_seen   += int'(peak_valid);
        rise_seen += int'(alarm_rise);
        fall_seen += int'(alarm_fall);
    endtask

    initial begin
        int pv0, f0, r0;
        rst = 1'b0; avg_valid = 1'b0; avg_in = 8'h00; clear = 1'b0;
        thr_high = 8'h80; thr_low = 8'h40;
        step(0, 8'h00, 0);
        step(1, 8'h90, 1);
        rst = 1'b1;

        // rise: 81, 90, 85
        r0 = rise_seen;
        step(1, 8'h81, 0); step(1, 8'h90, 0);
        chk("rise_not_early", 32'(alarm), 32'd0);
        step(1, 8'h85, 0);
        chk("rise_alarm", 32'(alarm), 32'd1);
        chk("rise_count", 32'(event_count), 32'd1);
        chk("rise_pulses", 32'(rise_seen - r0), 32'd1);

        // fall with gaps: 3F, gap, 30, gap, gap, 20
        pv0 = pv_seen; f0 = fall_seen;
        step(1, 8'h3F, 0); step(0, 8'h00, 0); step(1, 8'h30, 0);
        step(0, 8'h00, 0); step(0, 8'h00, 0);
        chk("gap_hold_alarm", 32'(alarm), 32'd1);
        step(1, 8'h20, 0);
        chk("fall_alarm", 32'(alarm), 32'd0);
        chk("fall_pulse", 32'(alarm_fall), 32'd1);
        chk("fall_peak", 32'(peak_out), 32'h90);
        step(0, 8'h00, 0);
        chk("fall_pv_count", 32'(pv_seen - pv0), 32'd1);
        chk("fall_count", 32'(fall_seen - f0), 32'd1);

        // equality breaks the rise debounce; a fresh run needs all three samples
        step(1, 8'h81, 0); step(1, 8'h82, 0); step(1, 8'h80, 0);
        chk("eq_no_alarm", 32'(alarm), 32'd0);
        step(1, 8'h81, 0); step(1, 8'h81, 0);
        chk("eq_back_below", 32'(alarm), 32'd0);
        step(1, 8'h81, 0);
        chk("eq_then_rise", 32'(alarm), 32'd1);

        // equality on the fall side, then a clean fall
        step(1, 8'h10, 0); step(1, 8'h40, 0); step(1, 8'h10, 0); step(1, 8'h10, 0);
        chk("fall_eq_held", 32'(alarm), 32'd1);
        step(1, 8'h10, 0);
        chk("fall_after_eq", 32'(alarm), 32'd0);

        // repeated episodes saturate the narrow counter; last rise coincides with clear
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h81, 0); step(1, 8'h81, 0); step(1, 8'hA0 + 8'(i), (i == 4));
            step(1, 8'h10, 0); step(1, 8'h10, 0); step(1, 8'h10, 0);
        end
        chk("clear_on_rise", 32'(event_count), 32'd0);

        // reset mid rise-debounce
        step(1, 8'h81, 0); step(1, 8'h81, 0);
        rst = 1'b0;
        step(1, 8'h81, 0);
        rst = 1'b1;
        chk("rst_mid_alarm", 32'(alarm), 32'd0);
        step(1, 8'h81, 0); step(1, 8'h81, 0);
        chk("rst_full_deb", 32'(alarm), 32'd0);
        step(1, 8'h81, 0);
        chk("rst_then_rise", 32'(alarm), 32'd1);

        // inconsistent thresholds while alarmed
        pv0 = pv_seen; f0 = fall_seen;
        thr_low = 8'h90;
        for (int i = 0; i < 5; i++) step(1, 8'h95, 0);
        chk("cfg_err_set", 32'(cfg_err), 32'd1);
        chk("cfg_alarm_low", 32'(alarm), 32'd0);
        chk("cfg_one_fall", 32'(fall_seen - f0), 32'd1);
        chk("cfg_no_pv", 32'(pv_seen - pv0), 32'd0);
        thr_low = 8'h40;
        step(1, 8'h95, 0); step(1, 8'h95, 0);

        // threshold raised mid-debounce
        step(1, 8'h10, 0); step(1, 8'h10, 0); step(1, 8'h10, 0);
        step(1, 8'h84, 0);
        thr_high = 8'h85;
        step(1, 8'h84, 0); step(1, 8'h90, 0); step(1, 8'h90, 0);
        chk("thr_change_no_alarm", 32'(alarm), 32'd0);
        thr_high = 8'h80;

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/avg_threshold_monitor.md
AVG_THRESHOLD_MONITOR -- requirements
Module: avg_threshold_monitor

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 8, width of the averaged sample.
- DEBOUNCE, 3, consecutive qualifying valid samples needed to change alarm state; legal range 1..15.
- CNT_W, 16, width of the event counter.

REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset.
- avg_in  input  WIDTH  averaged sample from the upstream moving-average filter.
- avg_valid  input  1  avg_in is valid this cycle.
- thr_high  input  WIDTH  rise threshold.
- thr_low  input  WIDTH  fall threshold.
- clear  input  1  synchronous clear of event_count.
- alarm  output  1  registered alarm level.
- alarm_rise  output  1  one-cycle pulse on alarm 0->1.
- alarm_fall  output  1  one-cycle pulse on alarm 1->0.
- peak_out  output  WIDTH  maximum sample of the last completed alarm episode.
- peak_valid  output  1  one-cycle pulse; peak_out updated.
- event_count  output  CNT_W  number of alarm rises, saturating.
- cfg_err  output  1  registered flag, high while thr_low > thr_high.

Function
REQ-003 The FSM SHALL have states BELOW, RISE_PEND, ABOVE and FALL_PEND, plus a debounce counter deb_cnt.
REQ-004 The FSM and deb_cnt SHALL change only on cycles with avg_valid=1; with avg_valid=0, state, deb_cnt and peak tracking SHALL hold, so gaps neither break nor advance debounce.
REQ-005 A rise-qualifying sample SHALL satisfy avg_in > thr_high (strict). A fall-qualifying sample SHALL satisfy avg_in < thr_low (strict). Equality SHALL qualify for neither.
REQ-006 BELOW transitions:
- A rise-qualifying sample SHALL go to RISE_PEND with deb_cnt=1 and peak tracker = avg_in.
- If DEBOUNCE=1, it SHALL go directly to ABOVE.
REQ-007 RISE_PEND transitions:
- A rise-qualifying sample SHALL increment deb_cnt.
- When deb_cnt reaches DEBOUNCE, the FSM SHALL go to ABOVE and clear deb_cnt.
- A non-qualifying sample SHALL return to BELOW, clear deb_cnt and discard the peak tracker.
REQ-008 ABOVE and FALL_PEND SHALL behave symmetrically with fall-qualifying samples. Completion of the count SHALL go to BELOW. A non-qualifying sample in FALL_PEND SHALL return to ABOVE with deb_cnt cleared.
REQ-009 alarm SHALL be 1 exactly while the registered state is ABOVE or FALL_PEND.
REQ-010 alarm SHALL assert on the clock edge that samples the DEBOUNCE-th consecutive qualifying sample (latency 0 cycles after that edge, outputs registered).
REQ-011 alarm_rise and alarm_fall SHALL pulse high for exactly one cycle, coincident with the first cycle of the new alarm level.
REQ-012 The peak tracker SHALL update to max(tracker, avg_in) on every valid sample in RISE_PEND, ABOVE and FALL_PEND.
REQ-013 On FALL_PEND->BELOW, peak_out SHALL load the tracker value and peak_valid SHALL pulse with alarm_fall. At all other times peak_out SHALL hold.
REQ-014 event_count SHALL increment by 1 with each alarm_rise and saturate at all-ones.
REQ-015 clear SHALL have priority: event_count becomes 0 even on a cycle with a simultaneous rise. clear SHALL affect nothing else.
REQ-016 cfg_err SHALL register (thr_low > thr_high) every cycle.
REQ-017 While cfg_err=1, the FSM SHALL be forced to BELOW with deb_cnt cleared and no peak load. If alarm was 1, alarm_fall SHALL pulse once and peak_valid SHALL NOT pulse.
REQ-018 Threshold changes mid-debounce SHALL take effect on the next valid sample, with no restart beyond the rules above.

Reset
REQ-019 With rst=0 at a clock edge, the block SHALL set:
- state = BELOW, deb_cnt = 0, peak tracker = 0.
- alarm, alarm_rise, alarm_fall, peak_valid, cfg_err = 0.
- peak_out = 0, event_count = 0.
REQ-020 Reset SHALL override all inputs, including mid-RISE_PEND or mid-FALL_PEND. No pulse output SHALL fire on the first cycle after release.

Verification (DEBOUNCE=3, thr_high=0x80, thr_low=0x40)
REQ-021 Valid samples 0x81, 0x90, 0x85 SHALL produce alarm=1 after the third edge, one alarm_rise pulse and event_count=1.
REQ-022 Samples 0x81, 0x82, 0x80 SHALL leave alarm=0, and the FSM SHALL be back in BELOW (equality does not qualify).
REQ-023 In alarm after REQ-021, samples 0x3F, gap, 0x30, gap, gap, 0x20 with avg_valid low in gaps SHALL give:
- alarm_fall pulse after 0x20.
- peak_out=0x90 with one peak_valid pulse.
REQ-024 With event_count=0xFFFF, a new rise SHALL keep 0xFFFF. A rise with clear=1 in the same cycle SHALL yield 0.
REQ-025 rst=0 after two rise-qualifying samples SHALL clear all outputs. After release, 0x81 x3 SHALL require the full 3 samples to raise alarm.
REQ-026 With alarm=1, setting thr_low=0x90 SHALL give cfg_err=1, a single alarm_fall, no peak_valid, and alarm held at 0 while cfg_err=1.
